// File: rtl/collider_pkg.sv
// Shared types and default geometry for the multi-player terrain collider.
package collider_pkg;

    localparam int DEF_COORD_W    = 10;
    localparam int DEF_SCREEN_W   = 640;
    localparam int DEF_MAX_RADIUS = 15;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        SCAN,
        DRAIN,
        EVAL,
        NEXT,
        DONE
    } state_t;

    // ground_y carries the package coordinate width; instances keep COORD_W at the default.
    typedef struct packed {
        logic                   landed;
        logic                   bounce;
        logic [DEF_COORD_W-1:0] ground_y;
    } hit_t;

    localparam hit_t HIT_RESET = '{landed: 1'b0, bounce: 1'b0, ground_y: '1};

endpackage

// File: rtl/collider_scan_unit.sv
// Per-player datapath: footprint range clamp, column address counter and
// min-height / bounce accumulators fed by a 1-cycle-latency heightmap port.
module collider_scan_unit
    import collider_pkg::*;
#(
    parameter int COORD_W    = DEF_COORD_W,
    parameter int SCREEN_W   = DEF_SCREEN_W,
    parameter int MAX_RADIUS = DEF_MAX_RADIUS
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic               step,
    input  logic [COORD_W-1:0] x_in,
    input  logic [COORD_W-1:0] y_in,
    input  logic [COORD_W-1:0] r_in,
    input  logic [COORD_W-1:0] hmap_data,
    output logic [COORD_W-1:0] addr,
    output logic               at_hi,
    output logic               off_screen,
    output hit_t               result
);

    localparam int SW = COORD_W + 1;

    logic [COORD_W-1:0] r_clamp;
    logic [SW-1:0]      lo_s;
    logic [SW-1:0]      hi_s;
    logic [COORD_W-1:0] lo_c;
    logic [COORD_W-1:0] hi_c;

    logic [COORD_W-1:0] x_q;
    logic [COORD_W-1:0] y_q;
    logic [COORD_W-1:0] r_q;
    logic [COORD_W-1:0] hi_q;
    logic [COORD_W-1:0] min_y;
    logic [COORD_W-1:0] col_d;
    logic               rd_d;
    logic               bounce_acc;
    logic [SW-1:0]      bottom;

    // Range arithmetic is one bit wider so X-R below zero shows up as the sign bit.
    always_comb begin
        r_clamp = (r_in > COORD_W'(MAX_RADIUS)) ? COORD_W'(MAX_RADIUS) : r_in;
        lo_s    = {1'b0, x_in} - {1'b0, r_clamp};
        hi_s    = {1'b0, x_in} + {1'b0, r_clamp};
        lo_c    = lo_s[SW-1] ? '0 : lo_s[COORD_W-1:0];
        hi_c    = (hi_s > SW'(SCREEN_W - 1)) ? COORD_W'(SCREEN_W - 1) : hi_s[COORD_W-1:0];
    end

    assign off_screen = (x_in >= COORD_W'(SCREEN_W));
    assign at_hi      = (addr == hi_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q        <= '0;
            y_q        <= '0;
            r_q        <= '0;
            hi_q       <= '0;
            addr       <= '0;
            min_y      <= '1;
            col_d      <= '0;
            rd_d       <= 1'b0;
            bounce_acc <= 1'b0;
        end else begin
            rd_d  <= step;
            col_d <= addr;
            if (load) begin
                x_q        <= x_in;
                y_q        <= y_in;
                r_q        <= r_clamp;
                addr       <= lo_c;
                hi_q       <= hi_c;
                min_y      <= '1;
                bounce_acc <= 1'b0;
            end else begin
                if (step && !at_hi) begin
                    addr <= addr + 1'b1;
                end
                if (rd_d) begin
                    if (hmap_data < min_y) begin
                        min_y <= hmap_data;
                    end
                    if ((col_d != x_q) && (hmap_data < y_q)) begin
                        bounce_acc <= 1'b1;
                    end
                end
            end
        end
    end

    assign bottom = {1'b0, y_q} + {1'b0, r_q};

    always_comb begin
        result          = HIT_RESET;
        result.landed   = (bottom >= {1'b0, min_y});
        result.bounce   = bounce_acc;
        result.ground_y = min_y;
    end

endmodule

// File: rtl/multi_collider.sv
// Per-frame terrain collision engine: sequences N players through one scan
// unit and commits all results atomically with a done pulse.
module multi_collider
    import collider_pkg::*;
#(
    parameter int N_PLAYERS  = 2,
    parameter int COORD_W    = DEF_COORD_W,
    parameter int SCREEN_W   = DEF_SCREEN_W,
    parameter int MAX_RADIUS = DEF_MAX_RADIUS
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         frame_start,
    input  logic [N_PLAYERS*COORD_W-1:0] player_x,
    input  logic [N_PLAYERS*COORD_W-1:0] player_y,
    input  logic [N_PLAYERS*COORD_W-1:0] player_r,
    output logic                         hmap_rd,
    output logic [COORD_W-1:0]           hmap_addr,
    input  logic [COORD_W-1:0]           hmap_data,
    output logic                         busy,
    output logic                         done,
    output logic                         overrun,
    output logic [N_PLAYERS-1:0]         landed,
    output logic [N_PLAYERS-1:0]         bounce,
    output logic [N_PLAYERS*COORD_W-1:0] ground_y
);

    localparam int IDX_W = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    hit_t               shadow [N_PLAYERS];

    logic [COORD_W-1:0] x_sel;
    logic [COORD_W-1:0] y_sel;
    logic [COORD_W-1:0] r_sel;
    logic               unit_load;
    logic               unit_step;
    logic               at_hi;
    logic               off_screen;
    hit_t               unit_hit;

    assign x_sel     = player_x[idx*COORD_W +: COORD_W];
    assign y_sel     = player_y[idx*COORD_W +: COORD_W];
    assign r_sel     = player_r[idx*COORD_W +: COORD_W];
    assign unit_load = (state == LATCH);
    assign unit_step = (state == SCAN);
    assign hmap_rd   = unit_step;
    assign busy      = (state != IDLE);

    collider_scan_unit #(
        .COORD_W    (COORD_W),
        .SCREEN_W   (SCREEN_W),
        .MAX_RADIUS (MAX_RADIUS)
    ) u_scan (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (unit_load),
        .step       (unit_step),
        .x_in       (x_sel),
        .y_in       (y_sel),
        .r_in       (r_sel),
        .hmap_data  (hmap_data),
        .addr       (hmap_addr),
        .at_hi      (at_hi),
        .off_screen (off_screen),
        .result     (unit_hit)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            idx      <= '0;
            done     <= 1'b0;
            overrun  <= 1'b0;
            landed   <= '0;
            bounce   <= '0;
            ground_y <= '1;
            for (int unsigned p = 0; p < N_PLAYERS; p++) begin
                shadow[p] <= HIT_RESET;
            end
        end else begin
            done    <= 1'b0;
            overrun <= frame_start && (state != IDLE);
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        idx   <= '0;
                        state <= LATCH;
                    end
                end
                LATCH: begin
                    if (off_screen) begin
                        shadow[idx] <= HIT_RESET;
                        state       <= NEXT;
                    end else begin
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (at_hi) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: state <= EVAL;
                EVAL: begin
                    shadow[idx] <= unit_hit;
                    state       <= NEXT;
                end
                // Results are copied on entry to DONE so they change in the same cycle done is high.
                NEXT: begin
                    if (idx == IDX_W'(N_PLAYERS - 1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                        for (int unsigned p = 0; p < N_PLAYERS; p++) begin
                            landed[p]                   <= shadow[p].landed;
                            bounce[p]                   <= shadow[p].bounce;
                            ground_y[p*COORD_W +: COORD_W] <= shadow[p].ground_y;
                        end
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= LATCH;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
